// File: rtl/refill_pkg.sv
// Shared constants, parameter defaults and FSM state type for the line refill controller.
package refill_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_MEM_W   = 32;
  localparam int DEF_INDEX_W = 8;
  localparam int DEF_TAG_W   = 18;

  localparam int LINE_BYTES     = 64;
  localparam int WORDS_PER_LINE = 16;
  localparam int WORD_BYTES     = 4;
  localparam int BEAT_W         = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_W       = $clog2(LINE_BYTES);
  localparam int WORD_LSB       = $clog2(WORD_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/line_refill_ctrl_if.sv
// Bundle of the miss, memory and fill signals around the line refill controller.
// master: the controller itself; slave: the cache/memory side driving it.
interface line_refill_ctrl_if #(
  parameter int ADDR_W  = refill_pkg::DEF_ADDR_W,
  parameter int MEM_W   = refill_pkg::DEF_MEM_W,
  parameter int INDEX_W = refill_pkg::DEF_INDEX_W,
  parameter int TAG_W   = refill_pkg::DEF_TAG_W
);

  logic                            miss_valid;
  logic                            miss_ready;
  logic [ADDR_W-1:0]               miss_addr;
  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic [ADDR_W-1:0]               mem_req_addr;
  logic                            mem_rsp_valid;
  logic [MEM_W-1:0]                mem_rsp_data;
  logic                            fill_valid;
  logic [INDEX_W-1:0]              fill_index;
  logic [TAG_W-1:0]                fill_tag;
  logic [refill_pkg::OFFSET_W-1:0] fill_offset;
  logic [MEM_W-1:0]                fill_data;
  logic                            fill_done;
  logic                            busy;
  logic [31:0]                     refill_count;

  modport master (
    input  miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_index,
           fill_tag, fill_offset, fill_data, fill_done, busy, refill_count
  );

  modport slave (
    output miss_valid, miss_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  miss_ready, mem_req_valid, mem_req_addr, fill_valid, fill_index,
           fill_tag, fill_offset, fill_data, fill_done, busy, refill_count
  );

endinterface

// File: rtl/refill_beat_gen.sv
// Beat counter for one line refill: counts consumed beats, produces the byte
// offset of the current beat and flags the last beat of the line.
// REFILL_CRITICAL_WORD_FIRST_EN: offsets start at the missing word and wrap.
module refill_beat_gen
  import refill_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  input  logic [BEAT_W-1:0]   start_i,
`endif
  input  logic                clear_i,
  input  logic                advance_i,
  output logic [OFFSET_W-1:0] offset_o,
  output logic                last_o
);

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] word;

  // Next beat count: restart on a new line, step on each consumed beat.
  // NOTE: every path assigns beat_d after a default, so no latch is inferred.
  always_comb begin
    beat_d = beat_q;
    if (clear_i) begin
      beat_d = '0;
    end else if (advance_i) begin
      beat_d = beat_q + 1'b1;
    end
  end

  // Beat count register.
  // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic [BEAT_W-1:0] start_q;

  // Critical word captured at miss acceptance; the sum wraps modulo one line.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= '0;
    end else if (clear_i) begin
      start_q <= start_i;
    end
  end

  assign word = start_q + beat_q;
`else
  assign word = beat_q;
`endif

  assign offset_o = {word, {WORD_LSB{1'b0}}};
  assign last_o   = (beat_q == BEAT_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/line_refill_ctrl.sv
// Cache line refill controller: accepts a miss, issues one line read to memory,
// streams the returned beats into the cache array and signals line completion.
// REFILL_CRITICAL_WORD_FIRST_EN: fetch starts at the missing word.
module line_refill_ctrl
  import refill_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_W   = DEF_MEM_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int TAG_W   = DEF_TAG_W
) (
  input logic               clk,
  input logic               rst,
  line_refill_ctrl_if.master bus
);

  localparam int TAG_LSB = ADDR_W - TAG_W;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam logic [ADDR_W-1:0] REQ_MASK = ~ADDR_W'(WORD_BYTES - 1);
`else
  localparam logic [ADDR_W-1:0] REQ_MASK = ~ADDR_W'(LINE_BYTES - 1);
`endif

  state_e               state_q, state_d;
  logic                 accept;
  logic                 beat_take;
  logic                 beat_last;
  logic [OFFSET_W-1:0]  beat_offset;
  logic [ADDR_W-1:0]    addr_q;
  logic [INDEX_W-1:0]   index_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 fill_valid_q;
  logic [OFFSET_W-1:0]  fill_offset_q;
  logic [MEM_W-1:0]     fill_data_q;
  logic [31:0]          count_q;

  assign accept    = (state_q == ST_IDLE) && bus.miss_valid;
  assign beat_take = (state_q == ST_FILL) && bus.mem_rsp_valid;

  refill_beat_gen u_beat_gen (
    .clk       (clk),
    .rst       (rst),
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    .start_i   (bus.miss_addr[OFFSET_W-1 -: BEAT_W]),
`endif
    .clear_i   (accept),
    .advance_i (beat_take),
    .offset_o  (beat_offset),
    .last_o    (beat_last)
  );

  // Next state and the state-decoded handshake/status outputs.
  always_comb begin
    state_d           = state_q;
    bus.miss_ready    = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.fill_done     = 1'b0;
    bus.busy          = 1'b1;
    case (state_q)
      ST_IDLE: begin
        bus.miss_ready = 1'b1;
        bus.busy       = 1'b0;
        if (bus.miss_valid) state_d = ST_REQ;
      end
      ST_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (beat_take && beat_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        bus.fill_done = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset overrides any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Line identity, frozen from miss acceptance until the next miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      index_q <= '0;
      tag_q   <= '0;
    end else if (accept) begin
      addr_q  <= bus.miss_addr & REQ_MASK;
      index_q <= bus.miss_addr[OFFSET_W +: INDEX_W];
      tag_q   <= bus.miss_addr[TAG_LSB +: TAG_W];
    end
  end

  // Cache write port: one registered word per consumed beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_valid_q  <= 1'b0;
      fill_offset_q <= '0;
      fill_data_q   <= '0;
    end else begin
      fill_valid_q <= beat_take;
      if (beat_take) begin
        fill_offset_q <= beat_offset;
        fill_data_q   <= bus.mem_rsp_data;
      end
    end
  end

  // Completed-refill counter, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (state_q == ST_DONE) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.mem_req_addr = addr_q;
  assign bus.fill_valid   = fill_valid_q;
  assign bus.fill_index   = index_q;
  assign bus.fill_tag     = tag_q;
  assign bus.fill_offset  = fill_offset_q;
  assign bus.fill_data    = fill_data_q;
  assign bus.refill_count = count_q;

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Self-checking bench for line_refill_ctrl: directed scenarios plus randomized
// refills, compared every cycle against a transaction-level reference model.
module tb_line_refill_ctrl;
  import refill_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_refill_ctrl_if bus ();

  line_refill_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_req_addr(input logic [31:0] a);
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    return a & 32'hFFFF_FFFC;
`else
    return a & 32'hFFFF_FFC0;
`endif
  endfunction

  // ---------------- reference model (line-transaction view) ----------------
  bit          m_busy = 0, m_req_done = 0, m_done = 0, m_fv = 0;
  int          m_beats = 0, m_start = 0;
  logic [31:0] m_addr = '0, m_count = '0, m_fdata = '0;
  logic [5:0]  m_foff = '0;
  logic [7:0]  m_idx = '0;
  logic [17:0] m_tag = '0;

  // ---------------- observations of DUT behaviour ----------------
  int          cyc = 0, fv_seen = 0, done_seen = 0, log_n = 0;
  int          last_done_cyc = -1, last_acc_cyc = -1;
  logic [5:0]  log_off [64];
  logic [31:0] log_data[64];
  logic [31:0] obs_req_addr = '0;
  logic [7:0]  obs_idx = '0;
  logic [17:0] obs_tag = '0;

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      check("miss_ready", 32'(bus.miss_ready), 32'(!m_busy));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("mem_req_valid", 32'(bus.mem_req_valid), 32'(m_busy && !m_req_done));
      if (m_busy && !m_req_done) check("mem_req_addr", bus.mem_req_addr, m_addr);
      if (m_busy) begin
        check("fill_index", 32'(bus.fill_index), 32'(m_idx));
        check("fill_tag", 32'(bus.fill_tag), 32'(m_tag));
      end
      check("fill_valid", 32'(bus.fill_valid), 32'(m_fv));
      if (m_fv) begin
        check("fill_offset", 32'(bus.fill_offset), 32'(m_foff));
        check("fill_data", bus.fill_data, m_fdata);
      end
      check("fill_done", 32'(bus.fill_done), 32'(m_done));
      check("refill_count", bus.refill_count, m_count);
    end

    if (bus.mem_req_valid === 1'b1) obs_req_addr = bus.mem_req_addr;
    if (bus.fill_valid === 1'b1) begin
      fv_seen++;
      if (log_n < 64) begin
        log_off[log_n]  = bus.fill_offset;
        log_data[log_n] = bus.fill_data;
      end
      log_n++;
      obs_idx = bus.fill_index;
      obs_tag = bus.fill_tag;
    end
    if (bus.fill_done === 1'b1) begin
      done_seen++;
      last_done_cyc = cyc;
    end
    if (!rst && bus.miss_valid && bus.miss_ready === 1'b1) last_acc_cyc = cyc;

    // Advance the model with the inputs that the coming clock edge will see.
    if (rst) begin
      m_busy = 0; m_req_done = 0; m_done = 0; m_fv = 0; m_beats = 0; m_count = '0;
    end else begin
      m_fv = 0;
      if (m_done) begin
        m_done = 0;
        m_busy = 0;
        m_count = m_count + 32'd1;
      end else if (!m_busy) begin
        if (bus.miss_valid) begin
          m_busy = 1; m_req_done = 0; m_beats = 0;
          m_addr = exp_req_addr(bus.miss_addr);
          m_idx  = bus.miss_addr[13:6];
          m_tag  = bus.miss_addr[31:14];
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
          m_start = int'(bus.miss_addr[5:2]);
`else
          m_start = 0;
`endif
        end
      end else if (!m_req_done) begin
        if (bus.mem_req_ready) m_req_done = 1;
      end else if (bus.mem_rsp_valid) begin
        m_fv    = 1;
        m_fdata = bus.mem_rsp_data;
        m_foff  = 6'(((m_start + m_beats) % 16) * 4);
        m_beats++;
        if (m_beats == 16) m_done = 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] a);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = a;
    for (int k = 0; k < 100; k++) begin
      if (bus.miss_ready === 1'b1) begin
        step();
        bus.miss_valid = 1'b0;
        return;
      end
      step();
    end
    check("miss_accept_timeout", 32'd0, 32'd1);
    bus.miss_valid = 1'b0;
  endtask

  task automatic serve_line(input int rdy_dly, input int gap, input bit rnd,
                            input logic [31:0] base, input int nb);
    int k;
    for (k = 0; k < 100 && bus.mem_req_valid !== 1'b1; k++) step();
    if (k == 100) begin
      check("mem_req_timeout", 32'd0, 32'd1);
      return;
    end
    bus.mem_req_ready = 1'b0;
    for (int d = 0; d < rdy_dly; d++) begin
      bus.mem_rsp_valid = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.mem_rsp_data  = $urandom;
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rnd ? $urandom : base + 32'(i);
      step();
      bus.mem_rsp_valid = 1'b0;
      repeat (rnd ? $urandom_range(gap, 0) : gap) step();
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (bus.busy === 1'b0) return;
      step();
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_line(input string tag, input int st, input logic [31:0] base);
    check({tag, "_beats"}, 32'(log_n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check({tag, "_off"}, 32'(log_off[i]), 32'(((st + i) % 16) * 4));
      check({tag, "_data"}, log_data[i], base + 32'(i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    int st1, st3;
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;

    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    check("rst_miss_ready", 32'(bus.miss_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_fill_valid", 32'(bus.fill_valid), 32'd0);
    check("rst_fill_done", 32'(bus.fill_done), 32'd0);
    check("rst_fill_index", 32'(bus.fill_index), 32'd0);
    check("rst_refill_count", bus.refill_count, 32'd0);
    rst = 1'b0;
    step();

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    st1 = 1;  st3 = 15;
`else
    st1 = 0;  st3 = 0;
`endif

    // Line at 0x0001_2344, back-to-back beats 0xA0..0xAF.
    log_n = 0; done_seen = 0;
    bus.mem_req_ready = 1'b1;
    do_miss(32'h0001_2344);
    serve_line(0, 0, 0, 32'hA0, 16);
    wait_idle();
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    check("s1_req_addr", obs_req_addr, 32'h0001_2344);
    check("s1_first_off", 32'(log_off[0]), 32'h04);
    check("s1_last_off", 32'(log_off[15]), 32'h00);
`else
    check("s1_req_addr", obs_req_addr, 32'h0001_2340);
    check("s1_first_off", 32'(log_off[0]), 32'h00);
    check("s1_last_off", 32'(log_off[15]), 32'h3C);
`endif
    check("s1_index", 32'(obs_idx), 32'h8D);
    check("s1_tag", 32'(obs_tag), 32'h4);
    check("s1_last_data", log_data[15], 32'hAF);
    check("s1_done_count", 32'(done_seen), 32'd1);
    check("s1_refill_count", bus.refill_count, 32'd1);
    check("s1_model_count", m_count, 32'd1);
    check_line("s1", st1, 32'hA0);

    // Line at 0x0000_003C: the critical word is the last word of the line.
    log_n = 0;
    do_miss(32'h0000_003C);
    serve_line(0, 0, 0, 32'h50, 16);
    wait_idle();
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    check("s3_req_addr", obs_req_addr, 32'h0000_003C);
    check("s3_off0", 32'(log_off[0]), 32'h3C);
    check("s3_off1", 32'(log_off[1]), 32'h00);
`else
    check("s3_req_addr", obs_req_addr, 32'h0000_0000);
    check("s3_off0", 32'(log_off[0]), 32'h00);
    check("s3_off1", 32'(log_off[1]), 32'h04);
`endif
    check_line("s3", st3, 32'h50);
    check("s3_refill_count", bus.refill_count, 32'd2);

    // Slow memory, gapped beats, and a second miss held off during the refill.
    do_miss(32'hDEAD_BEE8);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h1234_5678;
    serve_line(5, 2, 0, 32'hB0, 16);
    bus.miss_valid = 1'b0;
    check("s4_accept_after_done", 32'(last_acc_cyc - last_done_cyc), 32'd1);
    serve_line(1, 1, 1, 32'h0, 16);
    wait_idle();
    check("s4_refill_count", bus.refill_count, 32'd4);

    // Reset after beat 7, then 8 stray beats.
    do_miss(32'h0BAD_F00C);
    serve_line(0, 0, 0, 32'hC0, 7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    fv_seen = 0; done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = $urandom;
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    step();
    step();
    check("s5_fill_valid_seen", 32'(fv_seen), 32'd0);
    check("s5_fill_done_seen", 32'(done_seen), 32'd0);
    check("s5_refill_count", bus.refill_count, 32'd0);
    check("s5_busy", 32'(bus.busy), 32'd0);

    // Randomized refills, occasional stray beats and mid-line resets.
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(3, 0)) begin
        bus.mem_rsp_valid = 1'($urandom_range(1, 0));
        bus.mem_rsp_data  = $urandom;
        step();
      end
      bus.mem_rsp_valid = 1'b0;
      do_miss($urandom);
      if ($urandom_range(7, 0) == 0) begin
        serve_line($urandom_range(4, 0), 2, 1, 32'h0, $urandom_range(15, 1));
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        serve_line($urandom_range(4, 0), 3, 1, 32'h0, 16);
      end
      wait_idle();
      step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
